// File: rtl/complex_uart_pkg.sv
// Shared types and constants for the challenge/response UART.
// The bit divider is derived from clock frequency (MHz) and baud rate.
package complex_uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        COMPUTE,
        SEND
    } state_t;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    function automatic int calcDiv(input int freqMhz, input int baud);
        return (freqMhz * 1_000_000) / baud;
    endfunction

endpackage

// File: rtl/complex_uart_byte_rx.sv
// 8N1 byte receiver: synchronizer, start detect, mid-bit sampling.
// Emits one-cycle valid or framing-error strobes per frame.
module complex_uart_byte_rx
    import complex_uart_pkg::*;
#(
    parameter int DIV = 138
) (
    input  logic       i_clk,
    input  logic       i_n_reset,
    input  logic       i_rx,
    output logic       o_valid,
    output logic       o_ferr,
    output logic [7:0] o_data
);

    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
    localparam logic [3:0]    STOP_IDX  = 4'(FRAME_BITS - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_armed;
    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [3:0]    r_bitIdx;
    logic [7:0]    r_shift;
    logic          r_valid;
    logic          r_ferr;

    // Synchronizer resets low so a line held low across reset can never arm.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_rx;
            r_sync2 <= r_sync1;
        end
    end

    // Bit index 0 is the start bit, 1..8 data, 9 the stop bit.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_armed  <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_bitIdx <= '0;
            r_shift  <= '0;
            r_valid  <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            if (!r_busy) begin
                if (!r_armed) begin
                    r_armed <= r_sync2;
                end else if (!r_sync2) begin
                    r_busy   <= 1'b1;
                    r_cnt    <= HALF_LOAD;
                    r_bitIdx <= '0;
                end
            end else if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_cnt    <= BIT_LOAD;
                r_bitIdx <= r_bitIdx + 1'b1;
                if (r_bitIdx == 4'd0) begin
                    if (r_sync2) begin
                        r_busy <= 1'b0;
                    end
                end else if (r_bitIdx == STOP_IDX) begin
                    r_busy  <= 1'b0;
                    r_armed <= r_sync2;
                    r_valid <= r_sync2;
                    r_ferr  <= !r_sync2;
                end else begin
                    r_shift <= {r_sync2, r_shift[7:1]};
                end
            end
        end
    end

    assign o_valid = r_valid;
    assign o_ferr  = r_ferr;
    assign o_data  = r_shift;

endmodule

// File: rtl/complex_uart.sv
// Challenge/response UART: collects N bytes, XORs them with a selected
// error pattern and transmits the response LSB byte first.
module complex_uart
    import complex_uart_pkg::*;
#(
    parameter int Challenge_Bit     = 8,
    parameter int frequency_clk_ref = 16,
    parameter int BAUD              = 115200
) (
    input  logic       clk,
    input  logic       n_reset,
    input  logic [7:0] error1,
    input  logic [7:0] error2,
    input  logic [7:0] error3,
    input  logic [7:0] error4,
    input  logic [7:0] error5,
    input  logic [7:0] error6,
    input  logic [7:0] error7,
    input  logic [7:0] error8,
    input  logic [7:0] error9,
    input  logic [7:0] error10,
    input  logic [7:0] error11,
    input  logic [7:0] error12,
    input  logic [7:0] error13,
    input  logic [7:0] error14,
    input  logic [7:0] error15,
    input  logic       uart_rx,
    output logic       uart_tx
);

    localparam int            DIV       = calcDiv(frequency_clk_ref, BAUD);
    localparam int            N         = Challenge_Bit / 8;
    localparam int            CW        = $clog2(DIV);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(DIV - 1);
    localparam logic [3:0]    LAST_BYTE = 4'(N - 1);
    localparam logic [3:0]    STOP_IDX  = 4'(FRAME_BITS - 1);
    localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS);

    state_t                   r_state;
    state_t                   w_next;
    logic [Challenge_Bit-1:0] r_challenge;
    logic [Challenge_Bit-1:0] w_chNext;
    logic [Challenge_Bit-1:0] r_txShift;
    logic [3:0]               r_byteCnt;
    logic [3:0]               r_txBit;
    logic [3:0]               r_txByte;
    logic [CW-1:0]            r_txCnt;
    logic                     r_tx;
    logic                     w_rxValid;
    logic                     w_rxFerr;
    logic [7:0]               w_rxData;
    logic [7:0]               w_err;
    logic                     w_lastByte;
    logic                     w_txDone;

    complex_uart_byte_rx #(.DIV(DIV)) u_rx (
        .i_clk     (clk),
        .i_n_reset (n_reset),
        .i_rx      (uart_rx),
        .o_valid   (w_rxValid),
        .o_ferr    (w_rxFerr),
        .o_data    (w_rxData)
    );

    always_comb begin
        w_err = 8'h00;
        case (r_challenge[3:0])
            4'd1:    w_err = error1;
            4'd2:    w_err = error2;
            4'd3:    w_err = error3;
            4'd4:    w_err = error4;
            4'd5:    w_err = error5;
            4'd6:    w_err = error6;
            4'd7:    w_err = error7;
            4'd8:    w_err = error8;
            4'd9:    w_err = error9;
            4'd10:   w_err = error10;
            4'd11:   w_err = error11;
            4'd12:   w_err = error12;
            4'd13:   w_err = error13;
            4'd14:   w_err = error14;
            4'd15:   w_err = error15;
            default: w_err = 8'h00;
        endcase
    end

    // New bytes enter at the top so the first byte ends up least significant.
    always_comb begin
        w_chNext                      = r_challenge >> 8;
        w_chNext[Challenge_Bit-1 -: 8] = w_rxData;
    end

    assign w_lastByte = (r_byteCnt == LAST_BYTE);
    assign w_txDone   = (r_state == SEND) && (r_txCnt == '0) &&
                        (r_txBit == STOP_IDX) && (r_txByte == LAST_BYTE);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, COLLECT: begin
                if (w_rxFerr) begin
                    w_next = IDLE;
                end else if (w_rxValid) begin
                    w_next = w_lastByte ? COMPUTE : COLLECT;
                end
            end
            COMPUTE: w_next = SEND;
            SEND:    if (w_txDone) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Transmit bit index: 0 start, 1..8 data, 9 stop; start bit drives on COMPUTE exit.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_challenge <= '0;
            r_txShift   <= '0;
            r_byteCnt   <= '0;
            r_txBit     <= '0;
            r_txByte    <= '0;
            r_txCnt     <= '0;
            r_tx        <= 1'b1;
        end else begin
            case (r_state)
                IDLE, COLLECT: begin
                    if (w_rxFerr) begin
                        r_byteCnt   <= '0;
                        r_challenge <= '0;
                    end else if (w_rxValid) begin
                        r_challenge <= w_chNext;
                        r_byteCnt   <= w_lastByte ? 4'd0 : r_byteCnt + 1'b1;
                    end
                end
                COMPUTE: begin
                    r_txShift <= r_challenge ^ {N{w_err}};
                    r_tx      <= 1'b0;
                    r_txCnt   <= BIT_LOAD;
                    r_txBit   <= '0;
                    r_txByte  <= '0;
                end
                SEND: begin
                    if (r_txCnt != '0) begin
                        r_txCnt <= r_txCnt - 1'b1;
                    end else begin
                        r_txCnt <= BIT_LOAD;
                        if (r_txBit == STOP_IDX) begin
                            r_txBit <= '0;
                            if (r_txByte != LAST_BYTE) begin
                                r_tx     <= 1'b0;
                                r_txByte <= r_txByte + 1'b1;
                            end
                        end else begin
                            r_txBit <= r_txBit + 1'b1;
                            if (r_txBit == LAST_DATA) begin
                                r_tx <= 1'b1;
                            end else begin
                                r_tx      <= r_txShift[0];
                                r_txShift <= r_txShift >> 1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign uart_tx = r_tx;

endmodule

// File: tb/tb_complex_uart.sv
// Self-checking bench for complex_uart at defaults (16 MHz, 115200, 8-bit).
// A frame monitor checks every tx cycle against a byte-level response model.
`timescale 1ns/100ps
module tb_complex_uart;

    localparam int DIV  = 138;
    localparam int HALF = DIV / 2;

    logic       clk     = 1'b0;
    logic       n_reset = 1'b1;
    logic       uart_rx = 1'b0;
    logic       uart_tx;
    logic [7:0] errVal [1:15];

    int         checks     = 0;
    int         errors     = 0;
    int         framesSeen = 0;
    logic [7:0] lastByte   = 8'h00;
    logic [7:0] expQ [$];
    bit         strict     = 1'b0;

    bit         inFrame = 1'b0;
    bit         haveExp = 1'b0;
    bit         bitBad  = 1'b0;
    bit         prevTx  = 1'b1;
    int         bitIdx  = 0;
    int         cyc     = 0;
    logic [7:0] expByte = 8'h00;
    logic [7:0] rxByte  = 8'h00;
    logic       expBit  = 1'b1;
    logic       badVal  = 1'b0;

    always #31.25 clk = ~clk;

    complex_uart dut (
        .clk     (clk),
        .n_reset (n_reset),
        .error1  (errVal[1]),
        .error2  (errVal[2]),
        .error3  (errVal[3]),
        .error4  (errVal[4]),
        .error5  (errVal[5]),
        .error6  (errVal[6]),
        .error7  (errVal[7]),
        .error8  (errVal[8]),
        .error9  (errVal[9]),
        .error10 (errVal[10]),
        .error11 (errVal[11]),
        .error12 (errVal[12]),
        .error13 (errVal[13]),
        .error14 (errVal[14]),
        .error15 (errVal[15]),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    function automatic logic [7:0] expResp(input logic [7:0] ch);
        logic [7:0] e;
        e = (ch[3:0] == 4'd0) ? 8'h00 : errVal[ch[3:0]];
        return ch ^ e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input bit stopVal, input int stopCycles);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = data[i];
            repeat (DIV) @(negedge clk);
        end
        uart_rx = stopVal;
        repeat (stopCycles) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic waitFrames(input int target, input string name);
        int n;
        n = 0;
        while (framesSeen < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (framesSeen < target) begin
            errors++;
            $display("[TB] FAIL %s_timeout: frames %0d, required %0d", name, framesSeen, target);
        end
    endtask

    task automatic waitQuiet();
        int quiet;
        int n;
        quiet = 0;
        n     = 0;
        while (quiet < 2 * 10 * DIV && n < 40000) begin
            @(negedge clk);
            n++;
            if (uart_tx === 1'b1 && !inFrame) quiet++;
            else quiet = 0;
        end
        checks++;
        if (quiet < 2 * 10 * DIV) begin
            errors++;
            $display("[TB] FAIL quiet_timeout: idle run %0d cycles, required %0d", quiet, 2 * 10 * DIV);
        end
    endtask

    task automatic sendExpect(input logic [7:0] ch, input logic [7:0] lit, input string name);
        int base;
        base = framesSeen;
        expQ.push_back(expResp(ch));
        applyStimulus(ch, 1'b1, DIV);
        waitFrames(base + 1, name);
        checkOutput(name, {24'd0, lastByte}, {24'd0, lit});
    endtask

    // Frame monitor: every tx cycle inside a frame must match the expected bit level.
    always @(negedge clk) begin
        if (!n_reset) begin
            checkOutput("tx_in_reset", {31'd0, uart_tx}, 32'd1);
            inFrame = 1'b0;
            prevTx  = 1'b1;
        end else begin
            if (!inFrame && prevTx && uart_tx === 1'b0) begin
                inFrame = 1'b1;
                bitIdx  = 0;
                cyc     = 0;
                bitBad  = 1'b0;
                haveExp = 1'b0;
                if (strict) begin
                    checks++;
                    if (expQ.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_frame: tx began a frame, required idle high");
                    end else begin
                        expByte = expQ.pop_front();
                        haveExp = 1'b1;
                    end
                end
            end
            if (inFrame) begin
                if (bitIdx == 0)      expBit = 1'b0;
                else if (bitIdx == 9) expBit = 1'b1;
                else if (haveExp)     expBit = expByte[bitIdx-1];
                else if (cyc == 0)    expBit = uart_tx;
                if (uart_tx !== expBit && !bitBad) begin
                    bitBad = 1'b1;
                    badVal = uart_tx;
                end
                if (cyc == HALF && bitIdx >= 1 && bitIdx <= 8) rxByte[bitIdx-1] = uart_tx;
                cyc++;
                if (cyc == DIV) begin
                    checks++;
                    if (bitBad) begin
                        errors++;
                        $display("[TB] FAIL frame_bit%0d: tx got %b, required %b for %0d cycles", bitIdx, badVal, expBit, DIV);
                    end
                    bitBad = 1'b0;
                    cyc    = 0;
                    bitIdx++;
                    if (bitIdx == 10) begin
                        inFrame = 1'b0;
                        framesSeen++;
                        lastByte = rxByte;
                    end
                end
            end
            prevTx = uart_tx;
        end
    end

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int base;
        int n;
        for (int k = 1; k <= 15; k++) errVal[k] = 8'(k);

        #1 n_reset = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("tx_reset_literal", {31'd0, uart_tx}, 32'd1);
        #7 n_reset = 1'b1;

        // Line held low from reset must never produce a frame.
        repeat (2000) @(negedge clk);
        checkOutput("no_frame_line_low", framesSeen, 0);

        // Toggling line: only well-formed frames tolerated, then no lock-up.
        for (int i = 0; i < 40; i++) begin
            #7000 uart_rx = ~uart_rx;
        end
        uart_rx = 1'b1;
        waitQuiet();
        strict = 1'b1;

        sendExpect(8'h35, 8'h30, "resp_35");
        sendExpect(8'h20, 8'h20, "resp_20");
        sendExpect(8'hFF, 8'hF0, "resp_FF");

        base = framesSeen;
        applyStimulus(8'h3A, 1'b0, DIV);
        repeat (3 * 10 * DIV) @(negedge clk);
        checkOutput("ferr_no_response", framesSeen - base, 0);
        sendExpect(8'h3A, 8'h30, "resp_3A_after_ferr");

        // Second challenge arrives while the first response is still going out.
        base = framesSeen;
        expQ.push_back(expResp(8'h35));
        applyStimulus(8'h35, 1'b1, HALF + 10);
        applyStimulus(8'h20, 1'b1, DIV);
        waitFrames(base + 1, "drop");
        repeat (3 * 10 * DIV) @(negedge clk);
        checkOutput("drop_count", framesSeen - base, 1);
        checkOutput("drop_byte", {24'd0, lastByte}, 32'h30);
        checkOutput("drop_queue", expQ.size(), 0);

        // Reset during response data bit 4 (a zero bit of 0x20).
        base = framesSeen;
        expQ.push_back(expResp(8'h20));
        applyStimulus(8'h20, 1'b1, DIV);
        n = 0;
        while (!(inFrame && bitIdx == 5 && cyc >= HALF) && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checkOutput("reach_bit4", {31'd0, inFrame}, 32'd1);
        checkOutput("tx_bit4_low", {31'd0, uart_tx}, 32'd0);
        #10 n_reset = 1'b0;
        #1 checkOutput("tx_async_reset", {31'd0, uart_tx}, 32'd1);
        repeat (10) @(negedge clk);
        #7 n_reset = 1'b1;
        repeat (3 * 10 * DIV) @(negedge clk);
        checkOutput("abort_no_resume", framesSeen - base, 0);
        checkOutput("abort_queue", expQ.size(), 0);
        sendExpect(8'hFF, 8'hF0, "resp_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
